// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: load/store funct3 codes,
// FSM state encoding and request bit positions on the core's memory port.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int READ_REQ_BIT  = 3;
    localparam int WRITE_REQ_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_if.sv
// Core-to-memory data port: request codes, address, store/load data and stall.
interface data_memory_if;

    logic [3:0]  DATA_MEM_READ;
    logic [2:0]  DATA_MEM_WRITE;
    logic [31:0] DATA_MEM_ADDR;
    logic [31:0] DATA_MEM_WRITE_DATA;
    logic [31:0] DATA_MEM_READ_DATA;
    logic        DATA_MEM_BUSYWAIT;

    modport master (
        output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
        input  DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT
    );

    modport slave (
        input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
        output DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte-enables and lane replication, load lane
// extraction with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_value
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = read_word[{addr_lo, 3'b000} +: 8];
        lane_half = read_word[{addr_lo[1], 4'b0000} +: 16];

        // Store code 11 falls through to the full-word case.
        case ({1'b0, funct3[1:0]})
            F3_SB: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
            end
            F3_SH: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_word = store_data;
            end
        endcase

        case (funct3)
            F3_LB:   load_value = {{24{lane_byte[7]}}, lane_byte};
            F3_LH:   load_value = {{16{lane_half[15]}}, lane_half};
            F3_LBU:  load_value = {24'd0, lane_byte};
            F3_LHU:  load_value = {16'd0, lane_half};
            default: load_value = read_word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Data-memory responder: fixed-latency access FSM stalling the core via
// BUSYWAIT, word-organised storage with byte-lane merge, registered load data.
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    data_memory_if.slave  bus
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t        state;
    logic [3:0]    count;
    logic [31:0]   read_data;
    logic [31:0]   mem [DEPTH];

    logic          rd_req;
    logic          wr_req;
    logic          req;
    logic          commit;
    logic [AW-1:0] idx;
    logic [2:0]    funct3;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [31:0]   load_value;
    logic [31:0]   read_word;
    logic          unused_addr;

    assign rd_req      = bus.DATA_MEM_READ[READ_REQ_BIT];
    assign wr_req      = bus.DATA_MEM_WRITE[WRITE_REQ_BIT];
    assign req         = rd_req | wr_req;
    assign idx         = bus.DATA_MEM_ADDR[AW+1:2];
    assign unused_addr = ^bus.DATA_MEM_ADDR[31:AW+2];
    assign funct3      = wr_req ? {1'b0, bus.DATA_MEM_WRITE[1:0]} : bus.DATA_MEM_READ[2:0];
    assign read_word   = mem[idx];

    // Commit lands on the edge ending the last stalled cycle; a reset on that
    // same edge suppresses it.
    assign commit = !RESET && req &&
                    (((state == ST_IDLE) && (LATENCY == 1)) ||
                     ((state == ST_BUSY) && (count == 4'd1)));

    assign bus.DATA_MEM_BUSYWAIT  = req && (state != ST_ACK);
    assign bus.DATA_MEM_READ_DATA = read_data;

    mem_lane_align u_align (
        .funct3     (funct3),
        .addr_lo    (bus.DATA_MEM_ADDR[1:0]),
        .store_data (bus.DATA_MEM_WRITE_DATA),
        .read_word  (read_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_value (load_value)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            count     <= '0;
            read_data <= '0;
        end else begin
            if (commit && rd_req && !wr_req) begin
                read_data <= load_value;
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        count <= LAT_M1;
                        state <= (LATENCY == 1) ? ST_ACK : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!req) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (commit) begin
                        state <= ST_ACK;
                        count <= '0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (commit && wr_req) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= store_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed and random accesses against a byte-array
// reference model, with a queue-based scoreboard checked on every ACK cycle.
module tb_data_memory;
    import mem_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_if bus();

    data_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mbytes [4*DEPTH];
    logic [31:0] last_rd;
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a);
        int unsigned p;
        int unsigned base;
        int v;
        p = a % (4 * DEPTH);
        case (f3)
            3'b000: begin
                v = int'(mbytes[p]);
                if (v > 127) v -= 256;
                return 32'(v);
            end
            3'b100: return 32'(mbytes[p]);
            3'b001, 3'b101: begin
                base = p - (p % 2);
                v = int'(mbytes[base]) + 256 * int'(mbytes[base+1]);
                if (f3 == 3'b001 && v > 32767) v -= 65536;
                return 32'(v);
            end
            default: begin
                base = p - (p % 4);
                return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
            end
        endcase
    endfunction

    task automatic st_model(input logic [1:0] code, input logic [31:0] a, input logic [31:0] d);
        int unsigned p;
        int unsigned base;
        p = a % (4 * DEPTH);
        case (code)
            2'b00: mbytes[p] = d[7:0];
            2'b01: begin
                base = p - (p % 2);
                mbytes[base]   = d[7:0];
                mbytes[base+1] = d[15:8];
            end
            default: begin
                base = p - (p % 4);
                for (int i = 0; i < 4; i++) mbytes[base+i] = d[8*i +: 8];
            end
        endcase
    endtask

    task automatic idle_bus();
        bus.DATA_MEM_READ       = 4'b0;
        bus.DATA_MEM_WRITE      = 3'b0;
        bus.DATA_MEM_ADDR       = 32'h0;
        bus.DATA_MEM_WRITE_DATA = 32'h0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.DATA_MEM_READ       = {rd, f3};
        bus.DATA_MEM_WRITE      = {wr, f3[1:0]};
        bus.DATA_MEM_ADDR       = a;
        bus.DATA_MEM_WRITE_DATA = wd;
    endtask

    // Called just after a rising edge; returns just after the edge ending ACK.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string name);
        int busy;
        bit acked;
        if (wr) st_model(f3[1:0], a, wd);
        else if (rd) last_rd = ld_model(f3, a);
        exp_q.push_back(last_rd);
        drive(rd, wr, f3, a, wd);
        busy = 0;
        acked = 0;
        for (int c = 0; c < 64 && !acked; c++) begin
            @(negedge clk);
            if (bus.DATA_MEM_BUSYWAIT) busy++;
            else acked = 1;
        end
        check({name, " busy_cycles"}, 32'(busy), 32'(LAT));
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.DATA_MEM_READ[3] || bus.DATA_MEM_WRITE[2]) && !bus.DATA_MEM_BUSYWAIT) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ack_unexpected: got read_data %h expected no ack", bus.DATA_MEM_READ_DATA);
            end else begin
                mon_exp = exp_q.pop_front();
                tests++;
                if (bus.DATA_MEM_READ_DATA !== mon_exp) begin
                    fails++;
                    $display("FAIL ack_read_data: got %h expected %h (addr %h)",
                             bus.DATA_MEM_READ_DATA, mon_exp, bus.DATA_MEM_ADDR);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] d;
        int kind;

        idle_bus();
        last_rd = 32'h0;
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset read_data", bus.DATA_MEM_READ_DATA, 32'h0);
            check("reset busywait", 32'(bus.DATA_MEM_BUSYWAIT), 32'h0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle read_data", bus.DATA_MEM_READ_DATA, 32'h0);
            check("idle busywait", 32'(bus.DATA_MEM_BUSYWAIT), 32'h0);
        end
        @(posedge clk);
        #1;

        access(0, 1, F3_SW, 32'h10, 32'hDEADBEEF, "sw 0x10");
        access(1, 0, F3_LW, 32'h10, 32'h0, "lw 0x10");
        check("lw 0x10 value", bus.DATA_MEM_READ_DATA, 32'hDEADBEEF);

        access(0, 1, F3_SW, 32'h20, 32'h12345678, "sw 0x20");
        access(0, 1, F3_SB, 32'h21, 32'h000000AA, "sb 0x21");
        access(1, 0, F3_LW, 32'h20, 32'h0, "lw after sb");
        check("sb merge", bus.DATA_MEM_READ_DATA, 32'h1234AA78);
        access(0, 1, F3_SH, 32'h22, 32'h0000BEEF, "sh 0x22");
        access(1, 0, F3_LW, 32'h20, 32'h0, "lw after sh");
        check("sh merge", bus.DATA_MEM_READ_DATA, 32'hBEEFAA78);

        access(0, 1, F3_SW, 32'h30, 32'h0000F080, "sw 0x30");
        access(1, 0, F3_LB, 32'h30, 32'h0, "lb");
        check("lb ext", bus.DATA_MEM_READ_DATA, 32'hFFFFFF80);
        access(1, 0, F3_LBU, 32'h30, 32'h0, "lbu");
        check("lbu ext", bus.DATA_MEM_READ_DATA, 32'h00000080);
        access(1, 0, F3_LH, 32'h30, 32'h0, "lh");
        check("lh ext", bus.DATA_MEM_READ_DATA, 32'hFFFFF080);
        access(1, 0, F3_LHU, 32'h30, 32'h0, "lhu");
        check("lhu ext", bus.DATA_MEM_READ_DATA, 32'h0000F080);

        // Aborted store: request dropped after two stalled cycles.
        access(0, 1, F3_SW, 32'h40, 32'h55AA55AA, "sw 0x40");
        drive(0, 1, F3_SW, 32'h40, 32'h11111111);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 idle_bus();
        @(negedge clk);
        check("abort busywait", 32'(bus.DATA_MEM_BUSYWAIT), 32'h0);
        @(posedge clk);
        #1;
        access(1, 0, F3_LW, 32'h40, 32'h0, "lw after abort");
        check("abort no commit", bus.DATA_MEM_READ_DATA, 32'h55AA55AA);

        // Reset during the commit cycle of a store.
        drive(0, 1, F3_SW, 32'h40, 32'h22222222);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 32'h0;
        check("mid reset read_data", bus.DATA_MEM_READ_DATA, 32'h0);
        access(1, 0, F3_LW, 32'h40, 32'h0, "lw after reset");
        check("reset no commit", bus.DATA_MEM_READ_DATA, 32'h55AA55AA);

        access(0, 1, F3_SW, 32'h1000, 32'hCAFEF00D, "sw wrap");
        access(1, 0, F3_LW, 32'h0, 32'h0, "lw wrap");
        check("wrap value", bus.DATA_MEM_READ_DATA, 32'hCAFEF00D);

        access(1, 0, F3_LW, 32'h10, 32'h0, "lw pre-both");
        access(1, 1, F3_SW, 32'h10, 32'h12121212, "rd+wr");
        check("rd+wr read_data held", bus.DATA_MEM_READ_DATA, 32'hDEADBEEF);
        access(1, 0, F3_LW, 32'h10, 32'h0, "lw post-both");
        check("rd+wr committed", bus.DATA_MEM_READ_DATA, 32'h12121212);

        for (int w = 0; w < 16; w++) begin
            d = $urandom();
            access(0, 1, F3_SW, 32'(4 * w), d, "rand init");
        end
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            a = {r[31:6], 6'(r[5:0])};
            d = $urandom();
            kind = int'($urandom_range(0, 9));
            if (kind < 5)
                access(1, 0, 3'($urandom_range(0, 7)), a, d, "rand load");
            else if (kind < 9)
                access(0, 1, 3'($urandom_range(0, 3)), a, d, "rand store");
            else
                access(1, 1, 3'($urandom_range(0, 3)), a, d, "rand both");
        end

        repeat (3) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
